// File: rtl/regfile_sequencer.sv
// Drives an external register file through a READ/SETUP/STROBE/HOLD cycle per instruction.
// The write strobe w comes straight from a flop, so downstream logic may use it as a clock edge.
module regfile_sequencer #(
  parameter int NrOfBits = 4
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [2:0]          opcode,
  input  logic [2:0]          rd,
  input  logic [2:0]          rs1,
  input  logic [2:0]          rs2,
  input  logic [NrOfBits-1:0] imm,
  output logic [3:0]          A,
  output logic [3:0]          B,
  input  logic [NrOfBits-1:0] rdata_a,
  input  logic [NrOfBits-1:0] rdata_b,
  output logic [3:0]          to,
  output logic [NrOfBits-1:0] data,
  output logic                w,
  output logic                busy,
  output logic                done,
  output logic                zero,
  output logic                carry
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDI = 3'd1;
  localparam logic [2:0] OP_MOV = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  typedef enum logic [2:0] {IDLE, READ, SETUP, STROBE, HOLD} state_t;

  state_t                state_reg, state_next;
  logic                  started_reg;
  logic [2:0]            op_reg, rd_reg;
  logic [NrOfBits-1:0]   imm_reg;
  logic [3:0]            a_reg, b_reg, to_reg;
  logic [NrOfBits-1:0]   data_reg;
  logic                  w_reg, w_next;
  logic                  done_reg, done_next;
  logic                  zero_reg, carry_reg;

  logic                  accept;
  logic [NrOfBits:0]     sum_ext, diff_ext;
  logic [NrOfBits-1:0]   result;
  logic                  result_carry;
  logic                  carry_we;

  // Ready only rises once a clock edge has been seen after reset release.
  assign instr_ready = started_reg && (state_reg == IDLE);
  assign accept      = instr_valid && instr_ready;
  assign busy        = (state_reg != IDLE);

  assign A     = a_reg;
  assign B     = b_reg;
  assign to    = to_reg;
  assign data  = data_reg;
  assign w     = w_reg;
  assign done  = done_reg;
  assign zero  = zero_reg;
  assign carry = carry_reg;

  always_comb begin
    sum_ext      = {1'b0, rdata_a} + {1'b0, rdata_b};
    diff_ext     = {1'b0, rdata_a} - {1'b0, rdata_b};
    result       = '0;
    result_carry = 1'b0;
    carry_we     = 1'b0;
    case (op_reg)
      OP_LDI: result = imm_reg;
      OP_MOV: result = rdata_a;
      OP_ADD: begin
        result       = sum_ext[NrOfBits-1:0];
        result_carry = sum_ext[NrOfBits];
        carry_we     = 1'b1;
      end
      OP_SUB: begin
        // The extension bit of the difference is the borrow (rs1 < rs2).
        result       = diff_ext[NrOfBits-1:0];
        result_carry = diff_ext[NrOfBits];
        carry_we     = 1'b1;
      end
      OP_AND:  result = rdata_a & rdata_b;
      OP_OR:   result = rdata_a | rdata_b;
      OP_XOR:  result = rdata_a ^ rdata_b;
      default: result = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    w_next     = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (opcode == OP_NOP) done_next  = 1'b1;
          else                  state_next = READ;
        end
      end
      READ:  state_next = SETUP;
      SETUP: begin
        state_next = STROBE;
        w_next     = 1'b1;
      end
      STROBE: begin
        state_next = HOLD;
        done_next  = 1'b1;
      end
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg   <= IDLE;
      started_reg <= 1'b0;
      op_reg      <= OP_NOP;
      rd_reg      <= '0;
      imm_reg     <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      to_reg      <= '0;
      data_reg    <= '0;
      w_reg       <= 1'b0;
      done_reg    <= 1'b0;
      zero_reg    <= 1'b0;
      carry_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      started_reg <= 1'b1;
      w_reg       <= w_next;
      done_reg    <= done_next;
      if (accept) begin
        op_reg  <= opcode;
        rd_reg  <= rd;
        imm_reg <= imm;
        if (opcode != OP_NOP) begin
          a_reg <= {1'b0, rs1};
          b_reg <= {1'b0, rs2};
        end
      end
      // Operands were presented during READ; capture result and flags on leaving it.
      if (state_reg == READ) begin
        data_reg <= result;
        to_reg   <= {1'b0, rd_reg};
        zero_reg <= (result == '0);
        if (carry_we) carry_reg <= result_carry;
      end
    end
  end

endmodule
